fetch_stage: RTL and testbench

- Instruction-fetch stage sitting directly upstream of the combinational instruction memory.
- Owns the program counter and drives pc_out to the memory. Samples the returned instruction into the IF/ID pipeline register for decode.
- Handles stall, branch/jump redirect with squash, and misaligned-target halt.

---
 rtl/fetch_stage_if.sv | 25 ++
 rtl/fetch_stage.sv | 85 ++++++++
 tb/tb_fetch_stage.sv | 234 +++++++++++++++++++++++
 3 files changed

// File: rtl/fetch_stage_if.sv
// Fetch-side bus: PC out to instruction memory, instruction back, hazard/redirect in, IF/ID out.
// Combinational signal bundle only; no latency.
// No backpressure of its own; stall_i is the only hold signal.
interface fetch_stage_if;
    logic [31:0] pc_out;
    logic [31:0] instr_in;
    logic        stall_i;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic [31:0] if_id_pc;
    logic [31:0] if_id_pc_plus4;
    logic [31:0] if_id_instr;
    logic        if_id_valid;
    logic        misalign_err;

    modport master (
        output pc_out, if_id_pc, if_id_pc_plus4, if_id_instr, if_id_valid, misalign_err,
        input  instr_in, stall_i, redirect_valid, redirect_pc
    );

    modport slave (
        input  pc_out, if_id_pc, if_id_pc_plus4, if_id_instr, if_id_valid, misalign_err,
        output instr_in, stall_i, redirect_valid, redirect_pc
    );
endinterface

// File: rtl/fetch_stage.sv
// Instruction fetch: owns the PC and registers the returned instruction into IF/ID.
// Latency: instruction at pc_out appears on if_id_instr one cycle later.
// Backpressure: stall_i holds PC and IF/ID; a redirect overrides a stall.
module fetch_stage #(
    parameter logic [31:0] RESET_VEC = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic          clk,
    input  logic          rst,
    fetch_stage_if.master bus
);
    typedef enum logic [1:0] {BOOT, RUN, HALT} state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] id_pc_q, id_pc_d;
    logic [31:0] id_pc4_q, id_pc4_d;
    logic [31:0] id_instr_q, id_instr_d;
    logic        id_vld_q, id_vld_d;
    logic        err_q, err_d;
    logic [31:0] pc_plus4;

    assign pc_plus4 = pc_q + 32'd4;

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        id_pc_d    = id_pc_q;
        id_pc4_d   = id_pc4_q;
        id_instr_d = id_instr_q;
        id_vld_d   = id_vld_q;
        err_d      = err_q;
        case (state_q)
            BOOT: state_d = RUN;
            RUN: begin
                if (bus.redirect_valid) begin
                    id_vld_d   = 1'b0;
                    id_instr_d = NOP_INSTR;
                    if (bus.redirect_pc[1:0] != 2'b00) begin
                        // Misaligned target: keep PC pointing at the last good fetch.
                        state_d = HALT;
                        err_d   = 1'b1;
                    end else begin
                        pc_d = bus.redirect_pc;
                    end
                end else if (!bus.stall_i) begin
                    id_pc_d    = pc_q;
                    id_pc4_d   = pc_plus4;
                    id_instr_d = bus.instr_in;
                    id_vld_d   = 1'b1;
                    pc_d       = pc_plus4;
                end
            end
            HALT: id_vld_d = 1'b0;
            default: state_d = BOOT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= BOOT;
            pc_q       <= RESET_VEC;
            id_pc_q    <= 32'd0;
            id_pc4_q   <= 32'd0;
            id_instr_q <= NOP_INSTR;
            id_vld_q   <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            id_pc_q    <= id_pc_d;
            id_pc4_q   <= id_pc4_d;
            id_instr_q <= id_instr_d;
            id_vld_q   <= id_vld_d;
            err_q      <= err_d;
        end
    end

    assign bus.pc_out         = pc_q;
    assign bus.if_id_pc       = id_pc_q;
    assign bus.if_id_pc_plus4 = id_pc4_q;
    assign bus.if_id_instr    = id_instr_q;
    assign bus.if_id_valid    = id_vld_q;
    assign bus.misalign_err   = err_q;
endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: per-cycle stimulus and expected post-edge outputs are queued together,
// then replayed one clock at a time against a combinational instruction memory.
module tb_fetch_stage;
    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef struct packed {
        logic [31:0] pc_out;
        logic [31:0] id_pc;
        logic [31:0] id_pc4;
        logic [31:0] id_instr;
        logic        id_vld;
        logic        err;
    } exp_t;

    typedef struct packed {
        logic        rst;
        logic        stall;
        logic        rv;
        logic [31:0] rpc;
    } stim_t;

    logic clk = 1'b0;
    logic rst;
    logic [31:0] mem [0:255];
    int total = 0;
    int bad = 0;
    exp_t  sb[$];
    stim_t st[$];

    fetch_stage_if bus ();

    fetch_stage #(.RESET_VEC(32'h0000_0000), .NOP_INSTR(NOP)) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    assign bus.instr_in = mem[bus.pc_out[9:2]];

    function automatic exp_t mk(logic [31:0] pc_out, logic [31:0] id_pc, logic [31:0] id_pc4,
                                logic [31:0] id_instr, logic id_vld, logic err);
        exp_t e;
        e.pc_out = pc_out; e.id_pc = id_pc; e.id_pc4 = id_pc4;
        e.id_instr = id_instr; e.id_vld = id_vld; e.err = err;
        return e;
    endfunction

    function automatic exp_t obs();
        return mk(bus.pc_out, bus.if_id_pc, bus.if_id_pc_plus4, bus.if_id_instr,
                  bus.if_id_valid, bus.misalign_err);
    endfunction

    function automatic stim_t sv(logic r, logic s, logic v, logic [31:0] p);
        stim_t x;
        x.rst = r; x.stall = s; x.rv = v; x.rpc = p;
        return x;
    endfunction

    function automatic exp_t rst_exp();
        return mk(32'h0, 32'h0, 32'h0, NOP, 1'b0, 1'b0);
    endfunction

    task automatic drive(stim_t s);
        rst = s.rst;
        bus.stall_i = s.stall;
        bus.redirect_valid = s.rv;
        bus.redirect_pc = s.rpc;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        exp_t e, g;
        int n = 0;
        st.push_back(sv(1, 0, 0, 0));         sb.push_back(rst_exp());
        st.push_back(sv(1, 0, 0, 0));         sb.push_back(rst_exp());
        st.push_back(sv(0, 1, 1, 32'h40));    sb.push_back(rst_exp());
        st.push_back(sv(0, 0, 0, 0));         sb.push_back(mk(32'h4, 32'h0, 32'h4, mem[0], 1, 0));
        while (st.size() > 0) begin
            drive(st.pop_front());
            tick();
            e = sb.pop_front(); g = obs(); total++;
            if (g !== e) begin
                bad++;
                $display("FAIL reset%0d got pc=%h ipc=%h ipc4=%h ins=%h v=%b e=%b want pc=%h ipc=%h ipc4=%h ins=%h v=%b e=%b",
                         n, g.pc_out, g.id_pc, g.id_pc4, g.id_instr, g.id_vld, g.err,
                         e.pc_out, e.id_pc, e.id_pc4, e.id_instr, e.id_vld, e.err);
            end
            n++;
        end
    endtask

    task automatic test_seq();
        exp_t e, g;
        int n = 0;
        for (int i = 1; i < 4; i++) begin
            st.push_back(sv(0, 0, 0, 0));
            sb.push_back(mk(32'(4 * (i + 1)), 32'(4 * i), 32'(4 * i + 4), mem[i], 1, 0));
        end
        while (st.size() > 0) begin
            drive(st.pop_front());
            tick();
            e = sb.pop_front(); g = obs(); total++;
            if (g !== e) begin
                bad++;
                $display("FAIL seq%0d got pc=%h ipc=%h ipc4=%h ins=%h v=%b e=%b want pc=%h ipc=%h ipc4=%h ins=%h v=%b e=%b",
                         n, g.pc_out, g.id_pc, g.id_pc4, g.id_instr, g.id_vld, g.err,
                         e.pc_out, e.id_pc, e.id_pc4, e.id_instr, e.id_vld, e.err);
            end
            n++;
        end
    endtask

    task automatic test_stall();
        exp_t e, g;
        int n = 0;
        st.push_back(sv(1, 0, 0, 0)); sb.push_back(rst_exp());
        st.push_back(sv(0, 0, 0, 0)); sb.push_back(rst_exp());
        st.push_back(sv(0, 0, 0, 0)); sb.push_back(mk(32'h4, 32'h0, 32'h4, mem[0], 1, 0));
        st.push_back(sv(0, 0, 0, 0)); sb.push_back(mk(32'h8, 32'h4, 32'h8, mem[1], 1, 0));
        st.push_back(sv(0, 1, 0, 0)); sb.push_back(mk(32'h8, 32'h4, 32'h8, mem[1], 1, 0));
        st.push_back(sv(0, 1, 0, 0)); sb.push_back(mk(32'h8, 32'h4, 32'h8, mem[1], 1, 0));
        st.push_back(sv(0, 0, 0, 0)); sb.push_back(mk(32'hC, 32'h8, 32'hC, mem[2], 1, 0));
        while (st.size() > 0) begin
            drive(st.pop_front());
            tick();
            e = sb.pop_front(); g = obs(); total++;
            if (g !== e) begin
                bad++;
                $display("FAIL stall%0d got pc=%h ipc=%h ipc4=%h ins=%h v=%b e=%b want pc=%h ipc=%h ipc4=%h ins=%h v=%b e=%b",
                         n, g.pc_out, g.id_pc, g.id_pc4, g.id_instr, g.id_vld, g.err,
                         e.pc_out, e.id_pc, e.id_pc4, e.id_instr, e.id_vld, e.err);
            end
            n++;
        end
    endtask

    task automatic test_redirect();
        exp_t e, g;
        int n = 0;
        st.push_back(sv(0, 1, 1, 32'h40)); sb.push_back(mk(32'h40, 32'h8, 32'hC, NOP, 0, 0));
        st.push_back(sv(0, 0, 0, 0));      sb.push_back(mk(32'h44, 32'h40, 32'h44, mem[16], 1, 0));
        st.push_back(sv(0, 0, 1, 32'h80)); sb.push_back(mk(32'h80, 32'h40, 32'h44, NOP, 0, 0));
        st.push_back(sv(0, 0, 0, 0));      sb.push_back(mk(32'h84, 32'h80, 32'h84, mem[32], 1, 0));
        while (st.size() > 0) begin
            drive(st.pop_front());
            tick();
            e = sb.pop_front(); g = obs(); total++;
            if (g !== e) begin
                bad++;
                $display("FAIL redir%0d got pc=%h ipc=%h ipc4=%h ins=%h v=%b e=%b want pc=%h ipc=%h ipc4=%h ins=%h v=%b e=%b",
                         n, g.pc_out, g.id_pc, g.id_pc4, g.id_instr, g.id_vld, g.err,
                         e.pc_out, e.id_pc, e.id_pc4, e.id_instr, e.id_vld, e.err);
            end
            n++;
        end
    endtask

    task automatic test_misalign();
        exp_t e, g;
        int n = 0;
        st.push_back(sv(0, 0, 1, 32'h22)); sb.push_back(mk(32'h84, 32'h80, 32'h84, NOP, 0, 1));
        for (int i = 0; i < 5; i++) begin
            st.push_back(sv(0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom));
            sb.push_back(mk(32'h84, 32'h80, 32'h84, NOP, 0, 1));
        end
        st.push_back(sv(1, 0, 0, 0)); sb.push_back(rst_exp());
        st.push_back(sv(0, 0, 0, 0)); sb.push_back(rst_exp());
        st.push_back(sv(0, 0, 0, 0)); sb.push_back(mk(32'h4, 32'h0, 32'h4, mem[0], 1, 0));
        while (st.size() > 0) begin
            drive(st.pop_front());
            tick();
            e = sb.pop_front(); g = obs(); total++;
            if (g !== e) begin
                bad++;
                $display("FAIL halt%0d got pc=%h ipc=%h ipc4=%h ins=%h v=%b e=%b want pc=%h ipc=%h ipc4=%h ins=%h v=%b e=%b",
                         n, g.pc_out, g.id_pc, g.id_pc4, g.id_instr, g.id_vld, g.err,
                         e.pc_out, e.id_pc, e.id_pc4, e.id_instr, e.id_vld, e.err);
            end
            n++;
        end
    endtask

    task automatic test_wrap();
        exp_t e, g;
        int n = 0;
        st.push_back(sv(0, 0, 1, 32'hFFFF_FFFC)); sb.push_back(mk(32'hFFFF_FFFC, 32'h0, 32'h4, NOP, 0, 0));
        st.push_back(sv(0, 0, 0, 0)); sb.push_back(mk(32'h0, 32'hFFFF_FFFC, 32'h0, mem[255], 1, 0));
        st.push_back(sv(0, 0, 0, 0)); sb.push_back(mk(32'h4, 32'h0, 32'h4, mem[0], 1, 0));
        st.push_back(sv(1, 0, 0, 0)); sb.push_back(rst_exp());
        st.push_back(sv(0, 0, 0, 0)); sb.push_back(rst_exp());
        st.push_back(sv(0, 0, 0, 0)); sb.push_back(mk(32'h4, 32'h0, 32'h4, mem[0], 1, 0));
        while (st.size() > 0) begin
            drive(st.pop_front());
            tick();
            e = sb.pop_front(); g = obs(); total++;
            if (g !== e) begin
                bad++;
                $display("FAIL wrap%0d got pc=%h ipc=%h ipc4=%h ins=%h v=%b e=%b want pc=%h ipc=%h ipc4=%h ins=%h v=%b e=%b",
                         n, g.pc_out, g.id_pc, g.id_pc4, g.id_instr, g.id_vld, g.err,
                         e.pc_out, e.id_pc, e.id_pc4, e.id_instr, e.id_vld, e.err);
            end
            n++;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got timeout want finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = {8'hA5, 16'(i), 8'h33};
        mem[0] = 32'h0050_0093;
        mem[1] = 32'h00a0_0113;
        mem[2] = 32'h0020_81b3;
        mem[3] = NOP;
        drive(sv(1, 0, 0, 0));
        test_reset();
        test_seq();
        test_stall();
        test_redirect();
        test_misalign();
        test_wrap();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
